// File: rtl/duc_hb_interp_x2_if.sv
// I/Q sample handshake bundle for duc_hb_interp_x2: upstream samples in, downstream samples out.
// The master side drives samples and downstream ready. The slave side is the filter stage.
interface duc_hb_interp_x2_if #(
   parameter int WIDTH = 16
);
   logic signed [WIDTH-1:0] i_inph_data;
   logic signed [WIDTH-1:0] i_quad_data;
   logic                    i_valid;
   logic                    o_ready;
   logic signed [WIDTH-1:0] o_inph_data;
   logic signed [WIDTH-1:0] o_quad_data;
   logic                    o_valid;
   logic                    i_ready;

   modport master (
      output i_inph_data, i_quad_data, i_valid, i_ready,
      input  o_ready, o_inph_data, o_quad_data, o_valid
   );

   modport slave (
      input  i_inph_data, i_quad_data, i_valid, i_ready,
      output o_ready, o_inph_data, o_quad_data, o_valid
   );
endinterface

// File: rtl/duc_hb_interp_x2.sv
// Halfband x2 interpolator: the even output follows its accept by 1 clk, and the odd output comes 1 clk later; o_ready=0 except when EMPTY, or in ODD while the downstream side is ready.
// The optional DUC_HB_SAT_EN macro clamps the odd output. Otherwise the odd output wraps to WIDTH bits.
module duc_hb_interp_x2 #(
   parameter int WIDTH = 16
) (
   input logic               i_clock,
   input logic               i_reset_n,
   duc_hb_interp_x2_if.slave bus
);
   localparam int AW = WIDTH + 19;
   localparam logic signed [15:0]   C0  = 16'sd19490;
   localparam logic signed [15:0]   C1  = -16'sd3768;
   localparam logic signed [15:0]   C2  = 16'sd662;
   localparam logic signed [AW-1:0] RND = AW'(16384);
`ifdef DUC_HB_SAT_EN
   localparam logic signed [AW-1:0] SMAX = AW'((2 ** (WIDTH - 1)) - 1);
   localparam logic signed [AW-1:0] SMIN = -SMAX - AW'(1);
`endif

   typedef enum logic [1:0] {S_EMPTY, S_EVEN, S_ODD} state_t;

   state_t                  state, state_nxt;
   logic                    rdy;
   logic                    accept;
   logic signed [WIDTH-1:0] di [6];
   logic signed [WIDTH-1:0] dq [6];
   logic signed [WIDTH-1:0] odd_i, odd_q;

   function automatic logic signed [WIDTH-1:0] hb_odd(
      input logic signed [WIDTH-1:0] x0, x1, x2, x3, x4, x5);
      logic signed [WIDTH:0]    p0, p1, p2;
      logic signed [WIDTH+16:0] m0, m1, m2;
      logic signed [AW-1:0]     acc;
      p0  = (WIDTH+1)'(x2) + (WIDTH+1)'(x3);
      p1  = (WIDTH+1)'(x1) + (WIDTH+1)'(x4);
      p2  = (WIDTH+1)'(x0) + (WIDTH+1)'(x5);
      m0  = (WIDTH+17)'(p0) * (WIDTH+17)'(C0);
      m1  = (WIDTH+17)'(p1) * (WIDTH+17)'(C1);
      m2  = (WIDTH+17)'(p2) * (WIDTH+17)'(C2);
      acc = AW'(m0) + AW'(m1) + AW'(m2) + RND;
`ifdef DUC_HB_SAT_EN
      if ((acc >>> 15) > SMAX)
         hb_odd = WIDTH'(SMAX);
      else if ((acc >>> 15) < SMIN)
         hb_odd = WIDTH'(SMIN);
      else
         hb_odd = WIDTH'(acc >>> 15);
`else
      hb_odd = WIDTH'(acc >>> 15);
`endif
   endfunction

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n)
         state <= S_EMPTY;
      else
         state <= state_nxt;
   end

   // ODD releases its output and takes the next input on the same edge, so the stream has no bubble.
   always_comb begin
      state_nxt = state;
      rdy       = 1'b0;
      case (state)
         S_EMPTY: begin
            rdy = 1'b1;
            if (bus.i_valid)
               state_nxt = S_EVEN;
         end
         S_EVEN: begin
            if (bus.i_ready)
               state_nxt = S_ODD;
         end
         S_ODD: begin
            rdy = bus.i_ready;
            if (bus.i_ready)
               state_nxt = bus.i_valid ? S_EVEN : S_EMPTY;
         end
         default: state_nxt = S_EMPTY;
      endcase
   end

   assign accept      = bus.i_valid && rdy;
   assign bus.o_ready = rdy;

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int k = 0; k < 6; k++) begin
            di[k] <= '0;
            dq[k] <= '0;
         end
      end else if (accept) begin
         di[0] <= bus.i_inph_data;
         dq[0] <= bus.i_quad_data;
         for (int k = 1; k < 6; k++) begin
            di[k] <= di[k-1];
            dq[k] <= dq[k-1];
         end
      end
   end

   // The delay line is frozen outside accept, so recomputing in every EVEN cycle is stall-safe.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         odd_i <= '0;
         odd_q <= '0;
      end else if (state == S_EVEN) begin
         odd_i <= hb_odd(di[0], di[1], di[2], di[3], di[4], di[5]);
         odd_q <= hb_odd(dq[0], dq[1], dq[2], dq[3], dq[4], dq[5]);
      end
   end

   assign bus.o_valid     = (state != S_EMPTY);
   assign bus.o_inph_data = (state == S_ODD) ? odd_i : di[3];
   assign bus.o_quad_data = (state == S_ODD) ? odd_q : dq[3];
endmodule

// File: doc/duc_hb_interp_x2.md
# duc_hb_interp_x2

Halfband interpolate-by-2 FIR stage for the digital upconverter (DUC) transmit path; the interpolating counterpart of the receive-side halfband decimators. Each accepted complex input sample (I/Q) produces two output samples: a delayed copy of an input sample, then the interpolated midpoint. The stage uses a valid/ready handshake on both sides so that several stages can be cascaded toward the DAC rate.

## Interface
- WIDTH, 16, signed sample width of I and Q, input and output

- i_clock  in  1  single clock; all state updates on rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_inph_data  in  WIDTH  input I sample, signed
- i_quad_data  in  WIDTH  input Q sample, signed
- i_valid  in  1  input sample present
- o_ready  out  1  stage accepts an input this cycle
- o_inph_data  out  WIDTH  output I sample, signed
- o_quad_data  out  WIDTH  output Q sample, signed
- o_valid  out  1  output sample present
- i_ready  in  1  downstream accepts an output this cycle

## Operation
- Per rail, a 6-deep delay line d0 (newest) to d5 (oldest). On input acceptance (i_valid && o_ready) it shifts: d0 takes the new sample.
- 11-tap halfband with gain 2 folded into the coefficients, Q1.15: C0=19490 (d2,d3), C1=-3768 (d1,d4), C2=662 (d0,d5). Centre tap contributes exactly d3.
- Even output = d3. Odd output = (C0*(d2+d3) + C1*(d1+d4) + C2*(d0+d5) + 2^14) >>> 15.
- Arithmetic: pre-adds WIDTH+1 bits, products WIDTH+17 bits, accumulator WIDTH+19 bits, then round half-up and an arithmetic shift.
- FSM states:
  - EMPTY: o_valid=0, o_ready=1. Accept moves to EVEN.
  - EVEN: o_valid=1, output shows even sample, o_ready=0. i_ready moves to ODD.
  - ODD: o_valid=1, output shows odd sample, o_ready=i_ready. Handshake with accept moves to EVEN. Handshake without accept moves to EMPTY. If i_ready=0, stay in ODD.
- The odd result is registered every cycle in EVEN from the current delay line. The delay line changes only on accept, so the result stays valid under backpressure.
- I and Q use identical, independent datapaths that share the FSM.

## Timing
- Reset (asynchronous assert): delay line=0, state=EMPTY, o_valid=0, o_inph_data/o_quad_data=0, odd register=0. o_ready=1 from the first cycle after release.
- Latency: a sample accepted at edge k appears as an even output at the cycle after edge k+3 accepts. Group delay is 3 input samples plus 1 clock.
- First even output is valid the cycle after its accepting edge.
- Throughput: 1 input per 2 clocks with i_ready held high. Output is gap-free if i_valid stays high.
- While o_valid=1 and i_ready=0, o_*_data and o_valid hold stable (AXI-style; no retraction).
- Simultaneous odd-output handshake and new-input accept: new even output appears the next cycle with no bubble.
- Reset asserted mid-operation: the stage returns to the reset state immediately and the history is discarded. The first post-reset outputs reflect a zero history.
- o_ready is combinational from the state and i_ready only, with no path from i_valid.

## Configuration
- DUC_HB_SAT_EN defined: the odd result is clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1] before registering.
- DUC_HB_SAT_EN undefined: the result is truncated to the low WIDTH bits (two's-complement wrap).
- Even outputs never overflow, so they are unaffected by the macro.

## Test plan
- Reset: hold i_reset_n=0, then release -> o_valid=0, data=0, o_ready=1. Assert reset mid-stream -> o_valid drops in the same cycle, without waiting for a clock edge.
- Impulse: I = 16384 then zeros, i_valid=1, i_ready=1 -> I output sequence 0,331,0,-1884,0,9745,16384,9745,0,-1884,0,331, then zeros. Q stays 0.
- DC: I=Q=1000 continuous -> after 6 input samples, every output equals 1000 and o_valid stays high with no gaps.
- Backpressure: i_ready toggled randomly during the impulse test -> same output sequence, data held stable whenever o_valid && !i_ready, and o_ready=0 outside ODD.
- Overflow: inputs 32767, -32768, 32767, 32767, -32768, 32767 -> for the pair produced by the sixth accept:
  - even output = 32767;
  - odd output = 32767 with DUC_HB_SAT_EN defined, -17697 without.
- Throughput/overlap: i_valid=1 and i_ready=1 for 100 inputs -> exactly 200 outputs in 200 consecutive cycles after the first.
